redirect_unit: RTL
==================

# redirect_unit

Parametrised successor of the pipeline's branch/jump control. It arbitrates up to N_SRC redirect requests resolved in EX (conditional branch, JAL, JALR, ...) and drives the registered PC-mux select and redirect target. It generates IF/ID flush pulses of configurable length. A redirect that arrives while the hazard unit stalls the pipeline (load-use after a conditional branch) is held until the stall clears. The block also keeps a saturating count of issued redirects for performance monitoring.

## Interface
- XLEN, 32, PC/target width
- N_SRC, 3, number of redirect sources, 1..7; index 0 = highest priority
- SEL_W, 2, mux_to_pc width; must be >= clog2(N_SRC+1)
- FLUSH_CYCLES, 1, IF_Flush/ID_Flush assertion length, 1..8
- CNT_W, 16, redirect counter width
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- redirect_req  input  N_SRC  per-source redirect request, sampled each rising edge
- redirect_target  input  N_SRC*XLEN  source i target at bits [i*XLEN +: XLEN]
- stall  input  1  pipeline stall from hazard unit
- mux_to_pc  output  SEL_W  0 = PC+4, i+1 = take target of source i
- pc_target  output  XLEN  selected redirect target
- IF_Flush  output  1  flush IF/ID register
- ID_Flush  output  1  flush ID/EX register
- busy  output  1  high in HOLD or FLUSH
- redirect_cnt  output  CNT_W  number of redirects issued, saturating

## Operation
- All outputs are registered. Reset values: mux_to_pc=0, pc_target=0, IF_Flush=0, ID_Flush=0, busy=0, redirect_cnt=0. State resets to IDLE and any held request is cleared.
- Arbitration: among asserted redirect_req bits, the lowest index wins. The other requests in that cycle are discarded.
- Issue action (taken at one edge): mux_to_pc <= winner+1; pc_target <= winner target; IF_Flush, ID_Flush <= 1; redirect_cnt increments unless it is all-ones; flush counter <= FLUSH_CYCLES-1; state <= FLUSH.
- IDLE:
  - No request: outputs 0, except pc_target and redirect_cnt, which hold.
  - Request with stall=0: issue.
  - Request with stall=1: latch winner index and target; state <= HOLD. Outputs stay 0 and busy <= 1.
- HOLD:
  - While stall=1: keep the held request. New requests are ignored because the held request is older.
  - When stall=0: issue the held request using the stored target, not the current inputs. Any same-edge new request is dropped.
- FLUSH:
  - mux_to_pc <= 0 at the first edge after issue, so the redirect is applied exactly once.
  - IF_Flush and ID_Flush stay high while the counter is nonzero; the counter decrements per edge.
  - At the edge where the counter equals 0: flushes <= 0, busy <= 0, state <= IDLE.
  - All redirect_req values sampled in FLUSH are dropped; they belong to wrong-path instructions. stall has no effect in FLUSH.
- redirect_cnt counts issues only. Dropped or held-but-not-yet-issued requests do not count. At 2^CNT_W-1 it saturates.
- Reset while in HOLD or FLUSH: immediate return to reset values. The pending redirect is lost.

## Timing
- Latency: a request sampled at edge E (stall=0, IDLE) produces mux_to_pc/pc_target/flushes valid in cycle E..E+1.
- mux_to_pc is nonzero for exactly 1 cycle per issued redirect.
- Flushes are high for exactly FLUSH_CYCLES cycles, E through E+FLUSH_CYCLES.
- Requests at edges E+1..E+FLUSH_CYCLES are ignored. The earliest next issue is from a request sampled at edge E+FLUSH_CYCLES+1.
- Held redirect: stall falling, sampled low at edge S, issues at S with the same output timing as above.
- Back-to-back issue with FLUSH_CYCLES=1 has a minimum spacing of 2 cycles.

## Test plan
- Reset/idle: reset_n=0 mid-operation, then release with no requests. All outputs must be 0, busy=0, redirect_cnt=0.
- Single redirect (FLUSH_CYCLES=1): redirect_req=3'b010, target1=0x0000_0100. Next cycle: mux_to_pc=2, pc_target=0x100, both flushes=1, cnt=1. Following cycle: mux_to_pc=0 and flushes=0. A req on that edge is dropped; a req one edge later issues.
- Priority: redirect_req=3'b110, target1=0x200, target2=0x300. Expect mux_to_pc=2, pc_target=0x200, cnt increments by 1 only.
- Load-use hold: req0 with target 0x40 and stall=1 for 3 cycles, with req2 pulsed during the stall. No flush and mux_to_pc=0 while stalled, busy=1. When stall drops: mux_to_pc=1, pc_target=0x40; req2 never issues.
- Flush length: FLUSH_CYCLES=3 with one request. Flushes stay high exactly 3 cycles, mux_to_pc is nonzero for 1 cycle, and requests during the window are ignored. Reset asserted during the window clears everything the same cycle.
- Saturation: CNT_W=2 with 5 spaced requests. redirect_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/redirect_unit.sv
// Redirect arbiter for EX-resolved control transfers: picks one request, drives a
// one-shot registered PC-mux select/target, and produces IF/ID flush pulses.
module redirect_unit #(
    parameter int XLEN         = 32,
    parameter int N_SRC        = 3,
    parameter int SEL_W        = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_SRC-1:0]      redirect_req,
    input  logic [N_SRC*XLEN-1:0] redirect_target,
    input  logic                  stall,
    output logic [SEL_W-1:0]      mux_to_pc,
    output logic [XLEN-1:0]       pc_target,
    output logic                  IF_Flush,
    output logic                  ID_Flush,
    output logic                  busy,
    output logic [CNT_W-1:0]      redirect_cnt,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int FC_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] held_idx, held_idx_n;
    logic [XLEN-1:0]  held_tgt, held_tgt_n;
    logic [FC_W-1:0]  fcnt, fcnt_n;
    logic [SEL_W-1:0] mux_n;
    logic [XLEN-1:0]  tgt_n;
    logic             flush_n;
    logic             busy_n;
    logic [CNT_W-1:0] cnt_n;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [XLEN-1:0]  win_tgt;
    logic             do_issue;
    logic [IDX_W-1:0] iss_idx;
    logic [XLEN-1:0]  iss_tgt;

    assign state_dbg = state;

    // Lowest index wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        win_valid = |redirect_req;
        win_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (redirect_req[i]) win_idx = IDX_W'(i);
        end
        win_tgt = redirect_target[int'(win_idx)*XLEN +: XLEN];
    end

    always_comb begin
        state_n    = state;
        held_idx_n = held_idx;
        held_tgt_n = held_tgt;
        fcnt_n     = fcnt;
        mux_n      = '0;
        tgt_n      = pc_target;
        flush_n    = 1'b0;
        busy_n     = 1'b0;
        cnt_n      = redirect_cnt;
        do_issue   = 1'b0;
        iss_idx    = win_idx;
        iss_tgt    = win_tgt;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    if (stall) begin
                        state_n    = HOLD;
                        held_idx_n = win_idx;
                        held_tgt_n = win_tgt;
                        busy_n     = 1'b1;
                    end else begin
                        do_issue = 1'b1;
                    end
                end
            end
            HOLD: begin
                // The held request is older than anything arriving now, so new inputs are ignored.
                busy_n = 1'b1;
                if (!stall) begin
                    do_issue = 1'b1;
                    iss_idx  = held_idx;
                    iss_tgt  = held_tgt;
                end
            end
            FLUSH: begin
                // Requests seen here come from wrong-path instructions and are dropped.
                if (fcnt != '0) begin
                    fcnt_n  = fcnt - FC_W'(1);
                    flush_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_issue) begin
            mux_n   = SEL_W'(iss_idx) + SEL_W'(1);
            tgt_n   = iss_tgt;
            flush_n = 1'b1;
            busy_n  = 1'b1;
            fcnt_n  = FC_W'(FLUSH_CYCLES - 1);
            state_n = FLUSH;
            if (redirect_cnt != '1) cnt_n = redirect_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            held_idx     <= '0;
            held_tgt     <= '0;
            fcnt         <= '0;
            mux_to_pc    <= '0;
            pc_target    <= '0;
            IF_Flush     <= 1'b0;
            ID_Flush     <= 1'b0;
            busy         <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_n;
            held_idx     <= held_idx_n;
            held_tgt     <= held_tgt_n;
            fcnt         <= fcnt_n;
            mux_to_pc    <= mux_n;
            pc_target    <= tgt_n;
            IF_Flush     <= flush_n;
            ID_Flush     <= flush_n;
            busy         <= busy_n;
            redirect_cnt <= cnt_n;
        end
    end

endmodule
